// File: rtl/regfile_writeback.sv
// regfile_writeback: Y86-64 SEQ register file plus architectural state.
// Supplies the execute operands (ValA/ValB) combinationally from the
// pre-edge register contents. On each rising edge it retires one
// instruction: it writes ValE/ValM back, updates the ZF/SF/OF condition
// codes and advances the processor status. Once the status leaves AOK it
// stays there, and every later commit is blocked until reset.
module regfile_writeback #(
  parameter int          DATA_W = 64,
  parameter int          NREG   = 15,
  parameter logic [3:0]  RSP_ID = 4'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_vld,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              Cnd,
  input  logic              ZF_in,
  input  logic              SF_in,
  input  logic              OF_in,
  input  logic [DATA_W-1:0] ValE,
  input  logic [DATA_W-1:0] ValM,
  input  logic              dmem_err,
  output logic [DATA_W-1:0] ValA,
  output logic [DATA_W-1:0] ValB,
  output logic              ZF,
  output logic              SF,
  output logic              OF,
  output logic [2:0]        stat,
  input  logic [3:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  // Register id meaning "no register". It is never read from storage and
  // never written.
  localparam logic [3:0] RNONE = 4'hF;

  // Architectural status codes as seen on the stat port.
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  // Y86-64 instruction codes this block decodes.
  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_CMOVXX = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  // Architectural state.
  logic [DATA_W-1:0] regs [NREG];
  stat_e             stat_q;
  logic              zf_q;
  logic              sf_q;
  logic              of_q;

  // Decoded register ids.
  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;

  // Commit control.
  logic  mem_op;
  logic  commit_ok;
  stat_e stat_next;

  // ifun only qualifies cmov/jxx/OPq, and execute has already folded it into
  // Cnd and the flags. It is deliberately not decoded here.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  // Operand sources: which registers decode reads for ValA and ValB.
  always_comb begin
    // NOTE: every combinational output gets a default before the case. Any
    // path that leaves a variable unassigned would otherwise infer a latch.
    src_a = RNONE;
    src_b = RNONE;
    case (icode)
      I_CMOVXX: src_a = rA;
      I_RMMOVQ: begin
        src_a = rA;
        src_b = rB;
      end
      I_MRMOVQ: src_b = rB;
      I_OPQ: begin
        src_a = rA;
        src_b = rB;
      end
      I_CALL:   src_b = RSP_ID;
      I_RET: begin
        src_a = RSP_ID;
        src_b = RSP_ID;
      end
      I_PUSHQ: begin
        src_a = rA;
        src_b = RSP_ID;
      end
      I_POPQ: begin
        src_a = RSP_ID;
        src_b = RSP_ID;
      end
      default: ;
    endcase
  end

  // Write-back destinations. A cmov whose condition is false retires
  // without a register write.
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      I_CMOVXX: dst_e = Cnd ? rB : RNONE;
      I_IRMOVQ: dst_e = rB;
      I_MRMOVQ: dst_m = rA;
      I_OPQ:    dst_e = rB;
      I_CALL,
      I_RET,
      I_PUSHQ:  dst_e = RSP_ID;
      I_POPQ: begin
        dst_e = RSP_ID;
        dst_m = rA;
      end
      default: ;
    endcase
  end

  // Only instructions that touch data memory can raise an address error.
  always_comb begin
    mem_op = 1'b0;
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: mem_op = 1'b1;
      default: mem_op = 1'b0;
    endcase
  end

  // Status resolution, highest priority first: an invalid icode, then a
  // memory error, then halt. Nothing changes unless an instruction retires
  // while the machine is still AOK. commit_ok gates the register and CC
  // writes; halt still retires normally but has no destination.
  always_comb begin
    stat_next = stat_q;
    commit_ok = 1'b0;
    if (instr_vld && (stat_q == STAT_AOK)) begin
      if (icode > I_POPQ) begin
        stat_next = STAT_INS;
      end else if (dmem_err && mem_op) begin
        stat_next = STAT_ADR;
      end else begin
        commit_ok = 1'b1;
        if (icode == I_HALT) begin
          stat_next = STAT_HLT;
        end
      end
    end
  end

  // Register file write-back. ValM has priority over ValE, so that
  // popq %rsp loads the popped value rather than the incremented pointer.
  // Id 15 never matches a storage index, so RNONE writes drop out naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this storage is cleared by reset because software relies on
      // every register reading 0 after reset. Keep this storage in flops
      // rather than RAM macros, which cannot be reset.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (commit_ok) begin
      for (int i = 0; i < NREG; i++) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // read in this block therefore sees pre-edge values, and the
        // ordering of blocks cannot create races.
        if (dst_m == i[3:0]) begin
          regs[i] <= ValM;
        end else if (dst_e == i[3:0]) begin
          regs[i] <= ValE;
        end
      end
    end
  end

  // Condition codes: only OPq retiring normally loads new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (commit_ok && (icode == I_OPQ)) begin
      zf_q <= ZF_in;
      sf_q <= SF_in;
      of_q <= OF_in;
    end
  end

  // Processor status register. It is sticky because stat_next holds
  // whenever the current status is not AOK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= STAT_AOK;
    end else begin
      stat_q <= stat_next;
    end
  end

  // Operand and debug reads return pre-edge contents. There is no bypass,
  // and id 15 reads as zero.
  assign ValA     = (src_a   == RNONE) ? '0 : regs[src_a];
  assign ValB     = (src_b   == RNONE) ? '0 : regs[src_b];
  assign dbg_data = (dbg_idx == RNONE) ? '0 : regs[dbg_idx];

  assign ZF   = zf_q;
  assign SF   = sf_q;
  assign OF   = of_q;
  assign stat = stat_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed scenarios plus randomized retirement
// traffic for regfile_writeback. A behavioural model keeps the architectural
// state as plain arrays and updates it one whole instruction at a time.
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        instr_vld;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        cnd;
  logic        zf_in;
  logic        sf_in;
  logic        of_in;
  logic [63:0] val_e;
  logic [63:0] val_m;
  logic        dmem_err;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic        zf;
  logic        sf;
  logic        of;
  logic [2:0]  stat;
  logic [3:0]  dbg_idx;
  logic [63:0] dbg_data;

  int vectors;
  int miscompares;

  // Reference state. Entry 15 stands for RNONE and always stays 0.
  logic [63:0] m_regs [16];
  logic        m_zf;
  logic        m_sf;
  logic        m_of;
  logic [2:0]  m_stat;

  regfile_writeback #(.DATA_W(64), .NREG(15), .RSP_ID(4'd4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_vld(instr_vld), .icode(icode),
    .ifun(ifun), .rA(ra), .rB(rb), .Cnd(cnd), .ZF_in(zf_in),
    .SF_in(sf_in), .OF_in(of_in), .ValE(val_e), .ValM(val_m),
    .dmem_err(dmem_err), .ValA(val_a), .ValB(val_b), .ZF(zf), .SF(sf),
    .OF(of), .stat(stat), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] r);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return r;
    if (ic inside {4'h9, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] r);
    if (ic inside {4'h4, 4'h5, 4'h6}) return r;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_zf = 1'b1;
    m_sf = 1'b0;
    m_of = 1'b0;
    m_stat = 3'd1;
  endtask

  // Retire the instruction currently on the inputs, as the spec describes it.
  task automatic model_commit();
    logic [3:0] de;
    logic [3:0] dm;
    if (!rst_n || !instr_vld || m_stat != 3'd1) return;
    if (icode > 4'hB) begin
      m_stat = 3'd4;
      return;
    end
    if (dmem_err && (icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB})) begin
      m_stat = 3'd3;
      return;
    end
    if (icode == 4'h0) m_stat = 3'd2;
    de = 4'hF;
    dm = 4'hF;
    if (icode inside {4'h3, 4'h6} || (icode == 4'h2 && cnd)) de = rb;
    if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'd4;
    if (icode inside {4'h5, 4'hB}) dm = ra;
    if (de != 4'hF) m_regs[de] = val_e;
    if (dm != 4'hF) m_regs[dm] = val_m;   // applied last: ValM wins
    if (icode == 4'h6) begin
      m_zf = zf_in;
      m_sf = sf_in;
      m_of = of_in;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic derr);
    instr_vld = 1'b1;
    icode = ic;
    ifun = 4'($urandom);
    ra = a;
    rb = b;
    cnd = c;
    val_e = ve;
    val_m = vm;
    dmem_err = derr;
  endtask

  task automatic cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instr_vld = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(4'h3, 4'hF, 4'd9, 1'b0, 64'hDEAD, 64'hBEEF, 1'b0);
    instr_vld = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i);
      #1;
      vectors++;
      if (dbg_data !== 64'h0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h expected 0", i, dbg_data);
      end
    end
    vectors++;
    if ({zf, sf, of, stat} !== {1'b1, 1'b0, 1'b0, 3'd1}) begin
      miscompares++;
      $display("FAIL reset_cc_stat: got zf%b sf%b of%b stat%0d expected zf1 sf0 of0 stat1",
               zf, sf, of, stat);
    end
    // Idle cycles with busy-looking inputs must not disturb state.
    for (int k = 0; k < 3; k++) begin
      drive(4'h6, 4'd1, 4'd2, 1'b1, 64'h77, 64'h88, 1'b0);
      {zf_in, sf_in, of_in} = 3'b011;
      instr_vld = 1'b0;
      cycle();
    end
    dbg_idx = 4'd2;
    #1;
    vectors++;
    if ({dbg_data, zf, sf, of, stat} !== {64'h0, 1'b1, 1'b0, 1'b0, 3'd1}) begin
      miscompares++;
      $display("FAIL idle_hold: got reg2=%h zf%b sf%b of%b stat%0d expected reg2=0 zf1 sf0 of0 stat1",
               dbg_data, zf, sf, of, stat);
    end
  endtask

  task automatic test_irmovq();
    drive(4'h3, 4'hF, 4'd2, 1'b0, 64'h1234, 64'h5555, 1'b0);
    cycle();
    dbg_idx = 4'd2;
    #1;
    vectors++;
    if (dbg_data !== 64'h1234) begin
      miscompares++;
      $display("FAIL irmovq_reg2: got %h expected 1234", dbg_data);
    end
    drive(4'h6, 4'd2, 4'd2, 1'b0, 64'h2468, 64'h0, 1'b0);
    {zf_in, sf_in, of_in} = 3'b000;
    #1;
    vectors++;
    if (val_a !== 64'h1234 || val_b !== 64'h1234) begin
      miscompares++;
      $display("FAIL opq_operands: got a=%h b=%h expected a=1234 b=1234", val_a, val_b);
    end
    cycle();
    // Pre-edge read: the value just written is visible only after the edge.
    #1;
    vectors++;
    if (val_a !== 64'h2468) begin
      miscompares++;
      $display("FAIL opq_after_edge: got %h expected 2468", val_a);
    end
  endtask

  task automatic test_cmov();
    logic [2:0] cc_before;
    cc_before = {zf, sf, of};
    drive(4'h3, 4'hF, 4'd5, 1'b0, 64'h99, 64'h0, 1'b0);
    cycle();
    drive(4'h2, 4'd1, 4'd5, 1'b0, 64'h7, 64'h0, 1'b0);
    {zf_in, sf_in, of_in} = ~cc_before;
    cycle();
    dbg_idx = 4'd5;
    #1;
    vectors++;
    if (dbg_data !== 64'h99 || {zf, sf, of} !== cc_before) begin
      miscompares++;
      $display("FAIL cmov_cnd0: got reg5=%h cc=%b expected reg5=99 cc=%b",
               dbg_data, {zf, sf, of}, cc_before);
    end
    drive(4'h2, 4'd1, 4'd5, 1'b1, 64'h7, 64'h0, 1'b0);
    cycle();
    #1;
    vectors++;
    if (dbg_data !== 64'h7 || {zf, sf, of} !== cc_before) begin
      miscompares++;
      $display("FAIL cmov_cnd1: got reg5=%h cc=%b expected reg5=7 cc=%b",
               dbg_data, {zf, sf, of}, cc_before);
    end
  endtask

  task automatic test_popq_rsp();
    drive(4'h3, 4'hF, 4'd3, 1'b0, 64'h3333, 64'h0, 1'b0);
    cycle();
    drive(4'hB, 4'd4, 4'hF, 1'b0, 64'h108, 64'hAA, 1'b0);
    cycle();
    dbg_idx = 4'd4;
    #1;
    vectors++;
    if (dbg_data !== 64'hAA) begin
      miscompares++;
      $display("FAIL popq_rsp: got %h expected aa", dbg_data);
    end
    drive(4'hA, 4'd3, 4'hF, 1'b0, 64'hA2, 64'h0, 1'b0);
    #1;
    vectors++;
    if (val_a !== 64'h3333 || val_b !== 64'hAA) begin
      miscompares++;
      $display("FAIL pushq_operands: got a=%h b=%h expected a=3333 b=aa", val_a, val_b);
    end
    cycle();
    #1;
    vectors++;
    if (dbg_data !== 64'hA2) begin
      miscompares++;
      $display("FAIL pushq_rsp: got %h expected a2", dbg_data);
    end
  endtask

  task automatic test_cc();
    drive(4'h6, 4'd1, 4'd2, 1'b0, 64'h1, 64'h0, 1'b0);
    {zf_in, sf_in, of_in} = 3'b011;
    cycle();
    vectors++;
    if ({zf, sf, of} !== 3'b011) begin
      miscompares++;
      $display("FAIL cc_load: got %b expected 011", {zf, sf, of});
    end
    drive(4'h7, 4'd1, 4'd2, 1'b1, 64'h1, 64'h0, 1'b0);
    {zf_in, sf_in, of_in} = 3'b100;
    cycle();
    vectors++;
    if ({zf, sf, of} !== 3'b011) begin
      miscompares++;
      $display("FAIL cc_hold_jxx: got %b expected 011", {zf, sf, of});
    end
  endtask

  task automatic test_status();
    do_reset();
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    cycle();
    vectors++;
    if (stat !== 3'd2) begin
      miscompares++;
      $display("FAIL halt_stat: got %0d expected 2", stat);
    end
    drive(4'h3, 4'hF, 4'd1, 1'b0, 64'h55, 64'h0, 1'b0);
    cycle();
    drive(4'hC, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    cycle();
    dbg_idx = 4'd1;
    #1;
    vectors++;
    if (dbg_data !== 64'h0 || stat !== 3'd2) begin
      miscompares++;
      $display("FAIL halt_sticky: got reg1=%h stat%0d expected reg1=0 stat2", dbg_data, stat);
    end
    // dmem_err is ignored for instructions that do not access memory.
    do_reset();
    drive(4'h3, 4'hF, 4'd6, 1'b0, 64'h99, 64'h0, 1'b1);
    cycle();
    dbg_idx = 4'd6;
    #1;
    vectors++;
    if (dbg_data !== 64'h99 || stat !== 3'd1) begin
      miscompares++;
      $display("FAIL derr_nonmem: got reg6=%h stat%0d expected reg6=99 stat1", dbg_data, stat);
    end
    do_reset();
    drive(4'h5, 4'd6, 4'd1, 1'b0, 64'h40, 64'h77, 1'b1);
    cycle();
    #1;
    vectors++;
    if (dbg_data !== 64'h0 || stat !== 3'd3) begin
      miscompares++;
      $display("FAIL adr_stat: got reg6=%h stat%0d expected reg6=0 stat3", dbg_data, stat);
    end
    do_reset();
    drive(4'hC, 4'd1, 4'd1, 1'b0, 64'h0, 64'h0, 1'b0);
    cycle();
    vectors++;
    if (stat !== 3'd4) begin
      miscompares++;
      $display("FAIL ins_stat: got %0d expected 4", stat);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'h3, 4'hF, 4'd7, 1'b0, 64'hBEEF, 64'h0, 1'b0);
    cycle();
    drive(4'h3, 4'hF, 4'd7, 1'b0, 64'h1, 64'h0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    dbg_idx = 4'd7;
    #1;
    vectors++;
    if (dbg_data !== 64'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected 0", dbg_data);
    end
    cycle();
    vectors++;
    if (dbg_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_edge_write: got %h expected 0", dbg_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] exp_idx;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int pick;
      pick = int'($urandom_range(0, 99));
      drive((pick < 2) ? 4'h0 : (pick < 5) ? 4'($urandom_range(12, 15))
                                           : 4'($urandom_range(1, 11)),
            4'($urandom), 4'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 39) == 0));
      instr_vld = ($urandom_range(0, 7) != 0);
      {zf_in, sf_in, of_in} = 3'($urandom);
      dbg_idx = 4'($urandom);
      #1;
      vectors++;
      if (val_a !== m_regs[m_src_a(icode, ra)] || val_b !== m_regs[m_src_b(icode, rb)]) begin
        miscompares++;
        $display("FAIL rand_read[%0d]: got a=%h b=%h expected a=%h b=%h", n, val_a, val_b,
                 m_regs[m_src_a(icode, ra)], m_regs[m_src_b(icode, rb)]);
      end
      cycle();
      exp_idx = dbg_idx;
      vectors++;
      if ({zf, sf, of, stat} !== {m_zf, m_sf, m_of, m_stat} || dbg_data !== m_regs[exp_idx]) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: got zf%b sf%b of%b stat%0d r%0d=%h expected zf%b sf%b of%b stat%0d r%0d=%h",
                 n, zf, sf, of, stat, exp_idx, dbg_data,
                 m_zf, m_sf, m_of, m_stat, exp_idx, m_regs[exp_idx]);
      end
      if (m_stat != 3'd1 && $urandom_range(0, 3) == 0) do_reset();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1;
    instr_vld = 1'b0;
    icode = 4'h1;
    ifun = 4'h0;
    ra = 4'hF;
    rb = 4'hF;
    cnd = 1'b0;
    {zf_in, sf_in, of_in} = 3'b000;
    val_e = '0;
    val_m = '0;
    dmem_err = 1'b0;
    dbg_idx = 4'hF;
    model_reset();
    #2;
    test_reset();
    test_irmovq();
    test_cmov();
    test_popq_rsp();
    test_cc();
    test_status();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
